// File: rtl/major_cycle_sequencer_pkg.sv
// Shared definitions for the PDP-8 major-cycle sequencer.
//   major_t      : major-state encoding (IDLE=0, FETCH=1, DEFER=2, EXEC=3)
//   PHASE_W      : width of the minor-phase counter
//   PH_CK1..STB5 : minor-phase numbers; even = ckN, odd = stbN
package pdp8_seq_pkg;

  localparam int PHASE_W = 4;

  typedef enum logic [1:0] {
    MJ_IDLE  = 2'd0,
    MJ_FETCH = 2'd1,
    MJ_DEFER = 2'd2,
    MJ_EXEC  = 2'd3
  } major_t;

  localparam logic [PHASE_W-1:0] PH_CK1  = 4'd0;
  localparam logic [PHASE_W-1:0] PH_STB1 = 4'd1;
  localparam logic [PHASE_W-1:0] PH_CK2  = 4'd2;
  localparam logic [PHASE_W-1:0] PH_STB2 = 4'd3;
  localparam logic [PHASE_W-1:0] PH_CK3  = 4'd4;
  localparam logic [PHASE_W-1:0] PH_STB3 = 4'd5;
  localparam logic [PHASE_W-1:0] PH_CK4  = 4'd6;
  localparam logic [PHASE_W-1:0] PH_STB4 = 4'd7;
  localparam logic [PHASE_W-1:0] PH_CK5  = 4'd8;
  localparam logic [PHASE_W-1:0] PH_STB5 = 4'd9;

endpackage

// File: rtl/major_cycle_sequencer_if.sv
// Bundle between the sequencer, the front panel (run/step), the instruction
// decoders (instIs*, done, ck/stb) and the datapath controls.
//   master : the sequencer (drives pulses, controls, major, err)
//   slave  : decoder/datapath/panel side
interface major_cycle_sequencer_if;
  logic       run, step;
  logic       instIsMRI, instIsIND, instIsPPIND;
  logic       done;
  logic       ck1, ck2, ck3, ck4, ck5;
  logic       stb1, stb2, stb3, stb4, stb5;
  logic       pc2rama, ir_ck, pc_ck_fetch;
  logic       def_ir2rama, def_ram_oe, ind_ck;
  logic       def_ld2inc, def_inc2ramd, def_ram_we;
  logic [1:0] major;
  logic       err;

  modport master (
    input  run, step, instIsMRI, instIsIND, instIsPPIND, done,
    output ck1, ck2, ck3, ck4, ck5, stb1, stb2, stb3, stb4, stb5,
    output pc2rama, ir_ck, pc_ck_fetch, def_ir2rama, def_ram_oe, ind_ck,
    output def_ld2inc, def_inc2ramd, def_ram_we, major, err
  );

  modport slave (
    output run, step, instIsMRI, instIsIND, instIsPPIND, done,
    input  ck1, ck2, ck3, ck4, ck5, stb1, stb2, stb3, stb4, stb5,
    input  pc2rama, ir_ck, pc_ck_fetch, def_ir2rama, def_ram_oe, ind_ck,
    input  def_ld2inc, def_inc2ramd, def_ram_we, major, err
  );
endinterface

// File: rtl/major_cycle_sequencer_minor_phase_gen.sv
// Minor-phase counter and one-hot ck/stb decode.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : restart the count at phase 0 on the next edge
//   enable     : advance the count by one
//   active     : gate the ck/stb decode (only EXEC emits pulses)
//   phase      : registered phase, 0..9
//   ck, stb    : one-hot pulses, bit 0 = ck1/stb1
//   last_step  : phase is the final strobe allowed by EXEC_STEPS
module minor_phase_gen
  import pdp8_seq_pkg::*;
#(
  parameter int EXEC_STEPS = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               enable,
  input  logic               active,
  output logic [PHASE_W-1:0] phase,
  output logic [4:0]         ck,
  output logic [4:0]         stb,
  output logic               last_step
);

  always_ff @(posedge clk) begin
    if (!rst_n)      phase <= '0;
    else if (clear)  phase <= '0;
    else if (enable) phase <= phase + PHASE_W'(1);
  end

  always_comb begin
    ck  = '0;
    stb = '0;
    if (active) begin
      for (int unsigned i = 0; i < 5; i++) begin
        if (phase == PHASE_W'(2 * i))     ck[i]  = 1'b1;
        if (phase == PHASE_W'(2 * i + 1)) stb[i] = 1'b1;
      end
    end
  end

  assign last_step = (phase == PHASE_W'(2 * EXEC_STEPS - 1));

endmodule

// File: rtl/major_cycle_sequencer.sv
// PDP-8 major-cycle sequencer: steps each instruction through FETCH, optional
// DEFER (plain or autoindex) and EXEC, emitting ck/stb minor-phase pulses in
// EXEC and the fetch/defer datapath controls directly.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : master side of major_cycle_sequencer_if (run/step, decoder
//                flags and done in; pulses, controls, major, err out)
module major_cycle_sequencer
  import pdp8_seq_pkg::*;
#(
  parameter int EXEC_STEPS = 5,
  parameter bit AUTOINC_EN = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  major_cycle_sequencer_if.master   bus
);

  major_t             major_q, major_d;
  logic               err_q, err_d;
  logic [PHASE_W-1:0] phase;
  logic [4:0]         ck, stb;
  logic               last_step;
  logic               autoinc;

  assign autoinc = AUTOINC_EN && bus.instIsPPIND;

  // Phase restarts on every major-state change; it idles at 0 in IDLE.
  minor_phase_gen #(.EXEC_STEPS(EXEC_STEPS)) u_phase (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (major_d != major_q),
    .enable    (major_q != MJ_IDLE),
    .active    (major_q == MJ_EXEC),
    .phase     (phase),
    .ck        (ck),
    .stb       (stb),
    .last_step (last_step)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      major_q <= MJ_IDLE;
      err_q   <= 1'b0;
    end else begin
      major_q <= major_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    major_d = major_q;
    err_d   = err_q;
    unique case (major_q)
      MJ_IDLE:
        if (bus.run || bus.step) major_d = MJ_FETCH;
      MJ_FETCH:
        if (phase == PH_STB2)
          major_d = (bus.instIsMRI && (bus.instIsIND || bus.instIsPPIND))
                    ? MJ_DEFER : MJ_EXEC;
      MJ_DEFER:
        if (phase == (autoinc ? PH_STB2 : PH_STB1)) major_d = MJ_EXEC;
      MJ_EXEC:
        // done wins over the timeout if both land on the final strobe.
        if (bus.done) begin
          major_d = bus.run ? MJ_FETCH : MJ_IDLE;
        end else if (last_step) begin
          major_d = MJ_IDLE;
          err_d   = 1'b1;
        end
      default: major_d = MJ_IDLE;
    endcase
  end

  always_comb begin
    bus.pc2rama      = 1'b0;
    bus.ir_ck        = 1'b0;
    bus.pc_ck_fetch  = 1'b0;
    bus.def_ir2rama  = 1'b0;
    bus.def_ram_oe   = 1'b0;
    bus.ind_ck       = 1'b0;
    bus.def_ld2inc   = 1'b0;
    bus.def_inc2ramd = 1'b0;
    bus.def_ram_we   = 1'b0;
    case (major_q)
      MJ_FETCH: begin
        bus.pc2rama     = (phase == PH_CK1) || (phase == PH_STB1);
        bus.def_ram_oe  = (phase == PH_CK1) || (phase == PH_STB1);
        bus.ir_ck       = (phase == PH_STB1);
        bus.pc_ck_fetch = (phase == PH_STB2);
      end
      MJ_DEFER: begin
        bus.def_ir2rama = 1'b1;
        bus.def_ram_oe  = (phase == PH_CK1) || (phase == PH_STB1);
        if (autoinc) begin
          // Read pointer, bump it, write it back and latch the new value.
          bus.def_ld2inc   = (phase == PH_STB1);
          bus.def_inc2ramd = (phase == PH_CK2) || (phase == PH_STB2);
          bus.def_ram_we   = (phase == PH_STB2);
          bus.ind_ck       = (phase == PH_STB2);
        end else begin
          bus.ind_ck = (phase == PH_STB1);
        end
      end
      default: ;
    endcase
  end

  assign {bus.ck5, bus.ck4, bus.ck3, bus.ck2, bus.ck1}      = ck;
  assign {bus.stb5, bus.stb4, bus.stb3, bus.stb2, bus.stb1} = stb;
  assign bus.major = major_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_major_cycle_sequencer.sv
module tb_major_cycle_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  major_cycle_sequencer_if bus ();

  major_cycle_sequencer #(.EXEC_STEPS(5), .AUTOINC_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Control words {pc2rama, ir_ck, pc_ck_fetch, def_ir2rama, def_ram_oe,
  //                ind_ck, def_ld2inc, def_inc2ramd, def_ram_we}
  localparam logic [8:0] C_F0 = 9'h110, C_F1 = 9'h190, C_F2 = 9'h000, C_F3 = 9'h040;
  localparam logic [8:0] C_D0 = 9'h030, C_D1 = 9'h038;
  localparam logic [8:0] C_P0 = 9'h030, C_P1 = 9'h034, C_P2 = 9'h022, C_P3 = 9'h02B;

  function automatic logic [21:0] observed();
    return {bus.major, bus.err,
            bus.ck5, bus.ck4, bus.ck3, bus.ck2, bus.ck1,
            bus.stb5, bus.stb4, bus.stb3, bus.stb2, bus.stb1,
            bus.pc2rama, bus.ir_ck, bus.pc_ck_fetch, bus.def_ir2rama, bus.def_ram_oe,
            bus.ind_ck, bus.def_ld2inc, bus.def_inc2ramd, bus.def_ram_we};
  endfunction

  // Expected vector: ph < 0 means no ck/stb pulse.
  function automatic logic [21:0] ev(input logic [1:0] m, input logic e, input int ph,
                                     input logic [8:0] c);
    logic [4:0] ck, stb;
    ck  = '0;
    stb = '0;
    if (ph >= 0) begin
      if (ph % 2 == 0) ck[ph/2]  = 1'b1;
      else             stb[ph/2] = 1'b1;
    end
    return {m, e, ck, stb, c};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge: drive done, check the current cycle, move on.
  task automatic cyc(input string tag, input logic [21:0] exp, input logic d);
    bus.done = d;
    #1;
    check(tag, {10'd0, observed()}, {10'd0, exp});
    @(negedge clk);
  endtask

  task automatic do_fetch(input logic e);
    cyc("F0", ev(2'd1, e, -1, C_F0), 1'b0);
    cyc("F1", ev(2'd1, e, -1, C_F1), 1'b0);
    cyc("F2", ev(2'd1, e, -1, C_F2), 1'b0);
    cyc("F3", ev(2'd1, e, -1, C_F3), 1'b0);
  endtask

  task automatic do_defer_ind(input logic e);
    cyc("D0", ev(2'd2, e, -1, C_D0), 1'b0);
    cyc("D1", ev(2'd2, e, -1, C_D1), 1'b0);
  endtask

  task automatic do_defer_pp(input logic e);
    cyc("P0", ev(2'd2, e, -1, C_P0), 1'b0);
    cyc("P1", ev(2'd2, e, -1, C_P1), 1'b0);
    cyc("P2", ev(2'd2, e, -1, C_P2), 1'b0);
    cyc("P3", ev(2'd2, e, -1, C_P3), 1'b0);
  endtask

  task automatic do_exec(input logic e, input int done_ph, input int last_ph);
    for (int ph = 0; ph <= last_ph; ph++)
      cyc($sformatf("E%0d", ph), ev(2'd3, e, ph, 9'h000), ph == done_ph);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n           = 1'b0;
    bus.run         = 1'b1;
    bus.step        = 1'b0;
    bus.instIsMRI   = 1'b0;
    bus.instIsIND   = 1'b0;
    bus.instIsPPIND = 1'b0;
    bus.done        = 1'b0;

    repeat (3) begin
      @(negedge clk);
      check("reset", {10'd0, observed()}, {10'd0, ev(2'd0, 1'b0, -1, 9'h000)});
    end

    // Direct TAD, done at ck2: 7 cycles.
    rst_n = 1'b1;
    bus.instIsMRI = 1'b1;
    @(negedge clk);
    do_fetch(1'b0);
    do_exec(1'b0, 2, 2);

    // Indirect JMS, done at ck4: 13 cycles.
    bus.instIsIND = 1'b1;
    do_fetch(1'b0);
    do_defer_ind(1'b0);
    do_exec(1'b0, 6, 6);

    // Autoindex DCA, done at ck3.
    bus.instIsPPIND = 1'b1;
    do_fetch(1'b0);
    do_defer_pp(1'b0);
    do_exec(1'b0, 4, 4);

    // Direct MRI with done never raised: runs through stb5, then err.
    bus.instIsIND   = 1'b0;
    bus.instIsPPIND = 1'b0;
    do_fetch(1'b0);
    do_exec(1'b0, -1, 9);
    cyc("timeout_idle", ev(2'd0, 1'b1, -1, 9'h000), 1'b0);

    // Restart with err set; non-MRI with IND bit skips DEFER; run drops mid-way.
    bus.instIsMRI = 1'b0;
    bus.instIsIND = 1'b1;
    do_fetch(1'b1);
    bus.run = 1'b0;
    do_exec(1'b1, 1, 1);
    cyc("halt_idle0", ev(2'd0, 1'b1, -1, 9'h000), 1'b0);
    cyc("halt_idle1", ev(2'd0, 1'b1, -1, 9'h000), 1'b0);

    // Single step; a second step during EXEC must not start another instruction.
    bus.instIsMRI = 1'b1;
    bus.instIsIND = 1'b0;
    bus.step = 1'b1;
    cyc("step_idle", ev(2'd0, 1'b1, -1, 9'h000), 1'b0);
    bus.step = 1'b0;
    do_fetch(1'b1);
    bus.step = 1'b1;
    cyc("S_E0", ev(2'd3, 1'b1, 0, 9'h000), 1'b0);
    bus.step = 1'b0;
    cyc("S_E1", ev(2'd3, 1'b1, 1, 9'h000), 1'b0);
    cyc("S_E2", ev(2'd3, 1'b1, 2, 9'h000), 1'b0);
    cyc("S_E3", ev(2'd3, 1'b1, 3, 9'h000), 1'b0);
    cyc("S_E4", ev(2'd3, 1'b1, 4, 9'h000), 1'b1);
    for (int i = 0; i < 3; i++)
      cyc($sformatf("step_idle_after%0d", i), ev(2'd0, 1'b1, -1, 9'h000), 1'b0);

    // Reset mid-fetch: outputs clear on the next cycle and err returns to 0.
    bus.run = 1'b1;
    cyc("pre_fetch", ev(2'd0, 1'b1, -1, 9'h000), 1'b0);
    cyc("R_F0", ev(2'd1, 1'b1, -1, C_F0), 1'b0);
    cyc("R_F1", ev(2'd1, 1'b1, -1, C_F1), 1'b0);
    rst_n = 1'b0;
    cyc("R_F2", ev(2'd1, 1'b1, -1, C_F2), 1'b0);
    bus.run = 1'b0;
    cyc("mid_reset", ev(2'd0, 1'b0, -1, 9'h000), 1'b0);
    rst_n = 1'b1;
    cyc("post_reset_idle", ev(2'd0, 1'b0, -1, 9'h000), 1'b0);
    cyc("post_reset_idle2", ev(2'd0, 1'b0, -1, 9'h000), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
